// File: rtl/pll_loop_controller.sv
// Digital PLL loop controller: PFD edge detection, signed phase error, shift-gain PI filter,
// clamped DCO control word, lock detection and sticky timeout fault.
module pll_loop_controller #(
  parameter int N_BIT       = 8,
  parameter int CTRL_W      = 12,
  parameter int CTRL_INIT   = 2048,
  parameter int KP_SHIFT    = 1,
  parameter int KI_SHIFT    = 3,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT_MAX = 3
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    enable,
  input  logic                    ready,
  input  logic                    timeout,
  input  logic [N_BIT-1:0]        diff_1,
  input  logic [N_BIT-1:0]        diff_2,
  output logic [CTRL_W-1:0]       ctrl_word,
  output logic                    ctrl_valid,
  output logic signed [N_BIT:0]   phase_err,
  output logic                    locked,
  output logic                    fault
);

  localparam int IW  = CTRL_W + KI_SHIFT + 1;
  localparam int SW  = IW + 2;
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int TCW = $clog2(TIMEOUT_MAX + 1);

  localparam logic [CTRL_W-1:0]    INIT_W   = CTRL_W'(CTRL_INIT);
  localparam logic signed [SW-1:0] INIT_S   = SW'(CTRL_INIT);
  localparam logic [N_BIT:0]       TOL_V    = (N_BIT + 1)'(LOCK_TOL);
  localparam logic [LCW-1:0]       LOCK_MAX = LCW'(LOCK_COUNT);
  localparam logic [TCW-1:0]       TO_MAX   = TCW'(TIMEOUT_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, INTEG, OUTPUT} state_t;

  state_t                  state_q, state_d;
  logic                    ready_dly_q, timeout_dly_q;
  logic signed [N_BIT:0]   phase_err_q, phase_err_d;
  logic signed [IW-1:0]    integ_q, integ_d;
  logic [CTRL_W-1:0]       ctrl_word_q, ctrl_word_d;
  logic                    ctrl_valid_q, ctrl_valid_d;
  logic [LCW-1:0]          lock_cnt_q, lock_cnt_d;
  logic                    locked_q, locked_d;
  logic [TCW-1:0]          to_cnt_q, to_cnt_d;
  logic                    fault_q, fault_d;

  logic                    ready_rise, timeout_rise;
  logic signed [N_BIT:0]   perr_new, perr_neg, kp_term;
  logic [N_BIT:0]          perr_abs;
  logic signed [IW:0]      integ_sum;
  logic signed [IW-1:0]    integ_sat, ki_term;
  logic signed [SW-1:0]    sum;
  logic [CTRL_W-1:0]       ctrl_sat;

  assign ready_rise   = ready & ~ready_dly_q;
  assign timeout_rise = timeout & ~timeout_dly_q;
  assign perr_new     = $signed({1'b0, diff_1}) - $signed({1'b0, diff_2});
  assign perr_neg     = -phase_err_q;
  assign perr_abs     = phase_err_q[N_BIT] ? $unsigned(perr_neg) : $unsigned(phase_err_q);

  // One extra bit of headroom lets overflow be detected and clamped instead of wrapping.
  assign integ_sum = $signed({integ_q[IW-1], integ_q})
                   + $signed({{(IW - N_BIT){phase_err_q[N_BIT]}}, phase_err_q});
  assign integ_sat = (integ_sum[IW] != integ_sum[IW-1])
                   ? {integ_sum[IW], {(IW - 1){~integ_sum[IW]}}}
                   : integ_sum[IW-1:0];

  assign kp_term = phase_err_q >>> KP_SHIFT;
  assign ki_term = integ_q >>> KI_SHIFT;
  assign sum     = INIT_S
                 + $signed({{(SW - N_BIT - 1){kp_term[N_BIT]}}, kp_term})
                 + $signed({{(SW - IW){ki_term[IW-1]}}, ki_term});

  always_comb begin
    ctrl_sat = sum[CTRL_W-1:0];
    if (sum[SW-1])                ctrl_sat = '0;
    else if (|sum[SW-2:CTRL_W])   ctrl_sat = '1;
  end

  always_comb begin
    state_d      = state_q;
    phase_err_d  = phase_err_q;
    integ_d      = integ_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    to_cnt_d     = to_cnt_q;
    fault_d      = fault_q;
    if (!enable) begin
      state_d     = IDLE;
      phase_err_d = '0;
      integ_d     = '0;
      ctrl_word_d = INIT_W;
      lock_cnt_d  = '0;
      locked_d    = 1'b0;
      to_cnt_d    = '0;
      fault_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (ready_rise) begin
            phase_err_d = perr_new;
            to_cnt_d    = '0;
            state_d     = INTEG;
          end else if (timeout_rise) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TCW'(1);
            if (to_cnt_d == TO_MAX) fault_d = 1'b1;
          end
        end
        INTEG: begin
          integ_d = integ_sat;
          state_d = OUTPUT;
        end
        OUTPUT: begin
          ctrl_word_d  = ctrl_sat;
          ctrl_valid_d = 1'b1;
          if (perr_abs <= TOL_V) begin
            if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            lock_cnt_d = '0;
          end
          locked_d = (lock_cnt_d == LOCK_MAX);
          state_d  = WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      ready_dly_q   <= 1'b0;
      timeout_dly_q <= 1'b0;
      phase_err_q   <= '0;
      integ_q       <= '0;
      ctrl_word_q   <= INIT_W;
      ctrl_valid_q  <= 1'b0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
      to_cnt_q      <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_dly_q   <= ready;
      timeout_dly_q <= timeout;
      phase_err_q   <= phase_err_d;
      integ_q       <= integ_d;
      ctrl_word_q   <= ctrl_word_d;
      ctrl_valid_q  <= ctrl_valid_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
      to_cnt_q      <= to_cnt_d;
      fault_q       <= fault_d;
    end
  end

  assign ctrl_word  = ctrl_word_q;
  assign ctrl_valid = ctrl_valid_q;
  assign phase_err  = phase_err_q;
  assign locked     = locked_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_pll_loop_controller.sv
// Bench for pll_loop_controller: table of hand-computed results plus a reference model
// feeding a scoreboard queue for timeout, saturation and reset corner cases.
module tb_pll_loop_controller;

  logic              Clock, Reset, enable, ready, timeout;
  logic [7:0]        diff_1, diff_2;
  logic [11:0]       ctrl_word;
  logic              ctrl_valid;
  logic signed [8:0] phase_err;
  logic              locked, fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [11:0]       word;
    logic              locked;
    logic              fault;
    logic signed [8:0] perr;
  } exp_t;

  typedef struct {
    int          d1;
    int          d2;
    logic [11:0] word;
    logic        locked;
  } vec_t;

  exp_t sb_q[$];
  int   m_integ, m_lock, m_to, m_word;
  bit   m_fault;

  pll_loop_controller dut (
    .Clock(Clock), .Reset(Reset), .enable(enable), .ready(ready), .timeout(timeout),
    .diff_1(diff_1), .diff_2(diff_2), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
    .phase_err(phase_err), .locked(locked), .fault(fault)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_integ = 0; m_lock = 0; m_to = 0; m_word = 2048; m_fault = 0;
  endfunction

  function automatic exp_t model_result(int d1, int d2);
    exp_t e;
    int perr, s;
    perr = d1 - d2;
    m_integ = m_integ + perr;
    if (m_integ > 32767)  m_integ = 32767;
    if (m_integ < -32768) m_integ = -32768;
    s = 2048 + (perr >>> 1) + (m_integ >>> 3);
    if (s < 0)    s = 0;
    if (s > 4095) s = 4095;
    m_word = s;
    m_to = 0;
    if (perr <= 2 && perr >= -2) begin
      if (m_lock < 4) m_lock++;
    end else begin
      m_lock = 0;
    end
    e.word   = m_word[11:0];
    e.locked = (m_lock == 4);
    e.fault  = m_fault;
    e.perr   = perr[8:0];
    return e;
  endfunction

  task automatic do_result(int d1, int d2, bit with_to, exp_t e);
    exp_t got;
    int   lat;
    bit   seen;
    @(negedge Clock);
    diff_1 = d1[7:0]; diff_2 = d2[7:0]; ready = 1'b1; timeout = with_to;
    sb_q.push_back(e);
    seen = 0; lat = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge Clock);
      if (k == 1) begin ready = 1'b0; timeout = 1'b0; end
      if (ctrl_valid) begin seen = 1; lat = k; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL valid_wait: no ctrl_valid within 8 cycles");
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      check("latency",   lat, 3);
      check("ctrl_word", ctrl_word, got.word);
      check("locked",    locked, got.locked);
      check("fault",     fault, got.fault);
      check("phase_err", phase_err, got.perr);
      @(negedge Clock);
      check("valid_pulse", ctrl_valid, 0);
    end
  endtask

  task automatic do_timeout();
    @(negedge Clock);
    timeout = 1'b1;
    m_lock = 0;
    if (m_to < 3) m_to++;
    if (m_to == 3) m_fault = 1;
    @(negedge Clock);
    timeout = 1'b0;
    check("to_fault",  fault, m_fault);
    check("to_locked", locked, 0);
    check("to_word",   ctrl_word, m_word);
  endtask

  task automatic disable_loop();
    @(negedge Clock);
    enable = 1'b0;
    @(negedge Clock);
    check("dis_fault",  fault, 0);
    check("dis_word",   ctrl_word, 2048);
    check("dis_locked", locked, 0);
    check("dis_perr",   phase_err, 0);
    model_clear();
    enable = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    exp_t e;
    int   prev;
    bit   any_valid;

    vecs[0] = '{20, 0, 12'd2060, 1'b0};
    vecs[1] = '{20, 0, 12'd2063, 1'b0};
    vecs[2] = '{1,  0, 12'd2053, 1'b0};
    vecs[3] = '{1,  0, 12'd2053, 1'b0};
    vecs[4] = '{1,  0, 12'd2053, 1'b0};
    vecs[5] = '{1,  0, 12'd2053, 1'b1};
    vecs[6] = '{5,  0, 12'd2056, 1'b0};

    Reset = 1'b1; enable = 1'b0; ready = 1'b0; timeout = 1'b0;
    diff_1 = '0; diff_2 = '0;
    model_clear();
    repeat (2) @(negedge Clock);
    check("rst_word",   ctrl_word, 2048);
    check("rst_valid",  ctrl_valid, 0);
    check("rst_perr",   phase_err, 0);
    check("rst_locked", locked, 0);
    check("rst_fault",  fault, 0);
    Reset = 1'b0;
    @(negedge Clock);
    enable = 1'b1;

    // Hand-computed first update, integration and lock sequence.
    for (int i = 0; i < 7; i++) begin
      void'(model_result(vecs[i].d1, vecs[i].d2));
      e.word = vecs[i].word; e.locked = vecs[i].locked; e.fault = 1'b0;
      e.perr = 9'(vecs[i].d1 - vecs[i].d2);
      do_result(vecs[i].d1, vecs[i].d2, 1'b0, e);
    end

    repeat (3) do_timeout();
    check("fault_set", fault, 1);
    do_result(3, 0, 1'b0, model_result(3, 0));
    disable_loop();

    // Simultaneous ready and timeout: ready wins and clears the timeout count.
    do_timeout();
    do_result(4, 4, 1'b1, model_result(4, 4));
    do_timeout();
    do_timeout();
    check("ready_wins_nofault", fault, 0);
    disable_loop();

    prev = 4096;
    for (int i = 0; i < 140; i++) begin
      do_result(0, 255, 1'b0, model_result(0, 255));
      if (i == 0) check("sat_first", ctrl_word, 1888);
      check("sat_monotonic", int'(ctrl_word) <= prev, 1);
      prev = ctrl_word;
    end
    check("sat_floor", ctrl_word, 0);

    // Reset while in INTEG.
    @(negedge Clock);
    diff_1 = 8'd20; diff_2 = 8'd0; ready = 1'b1;
    @(negedge Clock);
    ready = 1'b0;
    check("mid_perr", phase_err, 20);
    Reset = 1'b1;
    #1;
    check("mid_rst_word",   ctrl_word, 2048);
    check("mid_rst_perr",   phase_err, 0);
    check("mid_rst_valid",  ctrl_valid, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_fault",  fault, 0);
    any_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      if (ctrl_valid) any_valid = 1;
    end
    check("mid_rst_no_pulse", any_valid, 0);
    Reset = 1'b0;
    model_clear();
    do_result(20, 0, 1'b0, model_result(20, 0));
    check("post_rst_word", ctrl_word, 2060);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
